// File: rtl/wb_retire_q.sv
// Writeback stage with a one-cycle RF/bypass write register and an
// in-order retire queue that feeds the trace/checker consumer.
module wb_retire_q #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [AW-1:0]              in_waddr,
  input  logic                       in_wen,
  input  logic [XLEN-1:0]            in_wdata,
  output logic                       wb_ready,
  output logic                       rf_wen,
  output logic [AW-1:0]              rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       ret_valid,
  input  logic                       ret_ready,
  output logic                       ret_wen,
  output logic [AW-1:0]              ret_waddr,
  output logic [XLEN-1:0]            ret_wdata,
  output logic [XLEN-1:0]            ret_pc,
  output logic [$clog2(DEPTH):0]     ret_count,
  output logic [31:0]                retired_total
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic            r_stg_valid;
  logic            r_stg_wen;
  logic [AW-1:0]   r_stg_waddr;
  logic [XLEN-1:0] r_stg_wdata;

  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [AW-1:0]   r_q_waddr [DEPTH];
  logic            r_q_wen   [DEPTH];
  logic [XLEN-1:0] r_q_wdata [DEPTH];

  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_total;

  logic            w_push;
  logic            w_pop;

  assign wb_ready  = (r_count < FULL);
  assign ret_valid = (r_count != '0);
  assign w_push    = in_valid && wb_ready;
  assign w_pop     = ret_valid && ret_ready;

  assign rf_wen   = r_stg_valid && r_stg_wen && (r_stg_waddr != '0);
  assign rf_waddr = r_stg_waddr;
  assign rf_wdata = r_stg_wdata;

  assign ret_pc        = r_q_pc[r_rp];
  assign ret_waddr     = r_q_waddr[r_rp];
  assign ret_wen       = r_q_wen[r_rp];
  assign ret_wdata     = r_q_wdata[r_rp];
  assign ret_count     = r_count;
  assign retired_total = r_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_valid <= 1'b0;
      r_stg_wen   <= 1'b0;
      r_stg_waddr <= '0;
      r_stg_wdata <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_total     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_waddr[i] <= '0;
        r_q_wen[i]   <= 1'b0;
        r_q_wdata[i] <= '0;
      end
    end else begin
      r_stg_valid <= w_push;
      if (w_push) begin
        r_stg_wen       <= in_wen;
        r_stg_waddr     <= in_waddr;
        r_stg_wdata     <= in_wdata;
        // x0 writes still retire, but never claim a register write
        r_q_pc[r_wp]    <= in_pc;
        r_q_waddr[r_wp] <= in_waddr;
        r_q_wen[r_wp]   <= in_wen && (in_waddr != '0);
        r_q_wdata[r_wp] <= in_wdata;
        r_wp            <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp    <= r_rp + PW'(1);
        r_total <= r_total + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_retire_q.sv
// Randomized bench for wb_retire_q against a queue-based model of
// acceptance, RF write pulses and in-order retirement.
module tb_wb_retire_q;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [AW-1:0]   in_waddr;
  logic            in_wen;
  logic [XLEN-1:0] in_wdata;
  logic            wb_ready;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            ret_valid;
  logic            ret_ready;
  logic            ret_wen;
  logic [AW-1:0]   ret_waddr;
  logic [XLEN-1:0] ret_wdata;
  logic [XLEN-1:0] ret_pc;
  logic [CW-1:0]   ret_count;
  logic [31:0]     retired_total;

  always #5 clk = ~clk;

  wb_retire_q #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_waddr(in_waddr),
    .in_wen(in_wen), .in_wdata(in_wdata), .wb_ready(wb_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_wen(ret_wen),
    .ret_waddr(ret_waddr), .ret_wdata(ret_wdata), .ret_pc(ret_pc),
    .ret_count(ret_count), .retired_total(retired_total)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [AW-1:0]   waddr;
    logic            wen;
    logic [XLEN-1:0] wdata;
  } ent_t;

  ent_t            m_q[$];
  ent_t            m_stg;
  logic            m_stg_v;
  logic [31:0]     m_total;
  bit              m_clean;
  int              exp_pulses;
  int              got_pulses;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_stg   = '{pc: '0, waddr: '0, wen: 1'b0, wdata: '0};
    m_stg_v = 1'b0;
    m_total = '0;
    m_clean = 1'b1;
  endtask

  task automatic check_outputs();
    logic exp_rf;
    exp_rf = m_stg_v && m_stg.wen && (m_stg.waddr != 0);
    if (rf_wen === 1'b1) got_pulses++;
    chk("wb_ready", 64'(wb_ready), 64'(m_q.size() < DEPTH));
    chk("ret_valid", 64'(ret_valid), 64'(m_q.size() != 0));
    chk("ret_count", 64'(ret_count), 64'(m_q.size()));
    chk("retired_total", 64'(retired_total), 64'(m_total));
    chk("rf_wen", 64'(rf_wen), 64'(exp_rf));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_stg.waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_stg.wdata));
    if (m_q.size() != 0) begin
      chk("ret_pc", 64'(ret_pc), 64'(m_q[0].pc));
      chk("ret_waddr", 64'(ret_waddr), 64'(m_q[0].waddr));
      chk("ret_wen", 64'(ret_wen), 64'(m_q[0].wen));
      chk("ret_wdata", 64'(ret_wdata), 64'(m_q[0].wdata));
    end else if (m_clean) begin
      chk("ret_pc_rst", 64'(ret_pc), 64'd0);
      chk("ret_wen_rst", 64'(ret_wen), 64'd0);
      chk("ret_wdata_rst", 64'(ret_wdata), 64'd0);
    end
  endtask

  // One clock: check settled outputs, drive inputs, advance the model.
  task automatic cyc(input logic v, input logic [XLEN-1:0] pc,
                     input logic [AW-1:0] wa, input logic we,
                     input logic [XLEN-1:0] wd, input logic rr,
                     input logic r);
    bit acc, pop;
    ent_t e;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_pc = pc; in_waddr = wa; in_wen = we;
    in_wdata = wd; ret_ready = rr; rst = r;
    if (r) begin
      m_reset();
    end else begin
      acc = v && (m_q.size() < DEPTH);
      pop = (m_q.size() != 0) && rr;
      m_stg_v = acc;
      if (pop) begin
        void'(m_q.pop_front());
        m_total++;
      end
      if (acc) begin
        e = '{pc: pc, waddr: wa, wen: we && (wa != 0), wdata: wd};
        m_stg = '{pc: pc, waddr: wa, wen: we, wdata: wd};
        m_q.push_back(e);
        m_clean = 1'b0;
        if (e.wen) exp_pulses++;
      end
    end
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, '0, '0, 1'b0, '0, rr, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] wa;
    exp_pulses = 0;
    got_pulses = 0;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_waddr = '0;
    in_wen = 1'b0; in_wdata = '0; ret_ready = 1'b0;
    m_reset();
    @(posedge clk);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);

    // single write, then its bypass pulse and retirement
    cyc(1'b1, 32'h1000, 5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1'b0);
    chk("single_rf_wdata", 64'(rf_wdata), 64'h0000_0000_DEAD_BEEF);
    idle(1'b1);
    idle(1'b0);

    // x0 write still retires
    cyc(1'b1, 32'h2000, 0, 1'b1, 32'h1234, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // fill with consumer stalled, hold a fifth, then release one
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'(i * 4), AW'(i + 1), 1'b1, 32'(i + 100), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h10, 5'd9, 1'b1, 32'h55, 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 5'd9, 1'b1, 32'h55, 1'b1, 1'b0);
    cyc(1'b1, 32'h10, 5'd9, 1'b1, 32'h55, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // steady push/pop at occupancy 2 across pointer wrap
    cyc(1'b1, 32'h300, 5'd3, 1'b1, 32'h3, 1'b0, 1'b0);
    cyc(1'b1, 32'h304, 5'd4, 1'b1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h308 + 32'(i * 4), AW'(i), 1'b1, 32'(i), 1'b1, 1'b0);
    chk("steady_count", 64'(ret_count), 64'd2);

    // reset at occupancy 3 with push and pop requested
    cyc(1'b1, 32'h400, 5'd1, 1'b1, 32'h1, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 32'h500, 5'd2, 1'b1, 32'h2, 1'b1, 1'b1);
    idle(1'b0);
    chk("rst_count", 64'(ret_count), 64'd0);

    for (int c = 0; c < 10000; c++) begin
      wa = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      cyc(1'($urandom), $urandom, wa, 1'($urandom), $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 999) == 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("rf_pulses", 64'(got_pulses), 64'(exp_pulses));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_retire_q.md
WB_RETIRE_Q -- requirements
Module: wb_retire_q

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath/PC width; AW, default 5, register-address width; DEPTH, default 4, retire-queue entries (power of two, >=2).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM->WB entry valid.
- in_pc  in  XLEN  PC of the instruction.
- in_waddr  in  AW  destination register.
- in_wen  in  1  register-write request.
- in_wdata  in  XLEN  write data.
- wb_ready  out  1  WB can accept an entry this cycle.
- rf_wen  out  1  register-file write enable, also the ID bypass valid.
- rf_waddr  out  AW  register-file/bypass address.
- rf_wdata  out  XLEN  register-file/bypass data.
- ret_valid  out  1  retire-queue head valid.
- ret_ready  in  1  retire consumer (trace/checker) accepts head.
- ret_wen  out  1  head write-enable (x0-filtered).
- ret_waddr  out  AW  head destination.
- ret_wdata  out  XLEN  head data.
- ret_pc  out  XLEN  head PC.
- ret_count  out  $clog2(DEPTH)+1  queue occupancy.
- retired_total  out  32  count of popped entries.

Function
REQ-003 An entry SHALL be accepted on a rising edge iff in_valid && wb_ready.
REQ-004 wb_ready SHALL be (ret_count < DEPTH), with no combinational dependence on ret_ready or in_valid.
REQ-005 An accepted entry SHALL be captured in one stage register (stage_valid, pc, waddr, wen, wdata); stage_valid SHALL be 1 for exactly the cycle after each acceptance and 0 otherwise.
REQ-006 rf_wen SHALL be stage_valid && stage_wen && (stage_waddr != 0); rf_waddr/rf_wdata SHALL equal the stage register. Latency: acceptance at edge N -> RF/bypass write visible in cycle N+1 only.
REQ-007 A write to x0 SHALL never assert rf_wen or ret_wen, but the entry SHALL still be retired.
REQ-008 Each accepted entry SHALL be pushed into a DEPTH-entry circular FIFO on the same edge, with ret_wen = in_wen && (in_waddr != 0) stored.
REQ-009 ret_valid SHALL be (ret_count != 0); ret_* data SHALL show the oldest entry; pop occurs on an edge iff ret_valid && ret_ready.
REQ-010 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-011 Push-only: ret_count +1. Pop-only: -1. Simultaneous push and pop: unchanged, head advances, new entry at tail.
REQ-012 Empty with simultaneous push: no pop that edge; ret_valid rises the next cycle (no fall-through).
REQ-013 Full: wb_ready=0, no push; a pop that edge makes wb_ready=1 next cycle.
REQ-014 ret_ready asserted while ret_valid=0 SHALL have no effect.
REQ-015 retired_total SHALL increment by 1 per pop and wrap modulo 2^32.
REQ-016 Retire order SHALL equal acceptance order; no entry lost or duplicated.

Reset
REQ-017 When rst is high at an edge: stage_valid, pointers, ret_count, retired_total SHALL clear to 0; stage and FIFO data SHALL clear to 0.
REQ-018 After reset: rf_wen=0, ret_valid=0, ret_wen=0, ret_* data=0, wb_ready=1.
REQ-019 rst SHALL override same-edge acceptance and pop; in-flight entries are discarded and not counted.

Verification
REQ-020 Single write: accept pc=0x1000, waddr=5, wen=1, wdata=0xDEADBEEF at edge N -> cycle N+1: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; ret_valid=1; ret_count=1; cycle N+2: rf_wen=0.
REQ-021 x0 filter: accept waddr=0, wen=1 -> rf_wen=0, ret_wen=0, entry retires, retired_total increments by 1.
REQ-022 Fill/backpressure, DEPTH=4, ret_ready=0: after 4 accepts -> wb_ready=0, ret_count=4; 5th in_valid held and not accepted; one pop -> wb_ready=1 next cycle, 5th accepted, FIFO order pc 0x0..0x10 preserved.
REQ-023 Concurrent push/pop at ret_count=2 for 10 cycles -> ret_count stays 2; pointers wrap; order preserved.
REQ-024 Mid-operation reset at ret_count=3, with in_valid=1 and ret_ready=1 on the same edge -> next cycle ret_count=0, ret_valid=0, rf_wen=0, retired_total=0, wb_ready=1.
REQ-025 Random in_valid/ret_ready over 10,000 cycles vs scoreboard -> in-order retirement, retired_total equals scoreboard pops, rf_wen pulses equal accepted entries with in_wen=1 and in_waddr!=0.
